// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a circular byte FIFO.
// Bytes are pushed over a valid/ready handshake. Queued bytes leave on
// tx_pin LSB first, back to back, with no idle gap between frames.
module uart_tx_fifo #(
   parameter int CLK_FRE    = 50,       // system clock in MHz
   parameter int BAUD_RATE  = 115200,   // line rate in bit/s
   parameter int FIFO_DEPTH = 16        // power of two, >= 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [7:0]                  tx_data,
   input  logic                        tx_data_valid,
   output logic                        tx_data_ready,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        tx_busy,
   output logic                        tx_pin
);

   localparam int CYCLES_PER_BIT = CLK_FRE * 1_000_000 / BAUD_RATE;
   localparam int AW             = $clog2(FIFO_DEPTH);
   localparam int PW             = AW + 1;
   localparam int CW             = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
   localparam logic [CW-1:0] BIT_LAST   = CW'(CYCLES_PER_BIT - 1);
   localparam logic [PW-1:0] FULL_COUNT = PW'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          empty;
   logic          do_write;
   logic          do_pop;
   logic          bit_end;
   logic [7:0]    head;

   state_t        state;
   logic [7:0]    shift;
   logic [CW-1:0] bit_cnt;
   logic [2:0]    bit_idx;

   // Pointers are one bit wider than the address, so plain subtraction
   // yields the occupancy and distinguishes full from empty.
   assign fifo_count    = wr_ptr - rd_ptr;
   assign empty         = (fifo_count == '0);
   assign tx_data_ready = (fifo_count != FULL_COUNT);
   assign do_write      = tx_data_valid && tx_data_ready;
   assign bit_end       = (bit_cnt == BIT_LAST);
   assign head          = mem[rd_ptr[AW-1:0]];
   assign tx_busy       = (state != IDLE) || !empty;

   // Pop when idle with data waiting, or at the end of a stop bit so the
   // next start bit follows without a gap.
   always_comb begin
      // NOTE: default first so every path assigns do_pop; otherwise a latch is inferred.
      do_pop = 1'b0;
      if (!empty) begin
         if (state == IDLE)
            do_pop = 1'b1;
         else if (state == STOP && bit_end)
            do_pop = 1'b1;
      end
   end

   // Storage array write port.
   always_ff @(posedge clk) begin
      // NOTE: the array is not reset; the pointers alone define which entries are valid.
      if (do_write)
         mem[wr_ptr[AW-1:0]] <= tx_data;
   end

   // Read and write pointers; reset empties the FIFO.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_write)
            wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + PW'(1);
      end
   end

   // Frame sequencer with registered line output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         tx_pin  <= 1'b1;
         shift   <= '0;
         bit_cnt <= '0;
         bit_idx <= '0;
      end else begin
         case (state)
            IDLE: begin
               tx_pin <= 1'b1;
               if (do_pop) begin
                  shift   <= head;
                  bit_cnt <= '0;
                  tx_pin  <= 1'b0;
                  state   <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  bit_cnt <= '0;
                  bit_idx <= '0;
                  tx_pin  <= shift[0];
                  state   <= DATA;
               end else begin
                  bit_cnt <= bit_cnt + CW'(1);
               end
            end
            DATA: begin
               if (bit_end) begin
                  bit_cnt <= '0;
                  shift   <= {1'b0, shift[7:1]};
                  if (bit_idx == 3'd7) begin
                     tx_pin <= 1'b1;
                     state  <= STOP;
                  end else begin
                     tx_pin  <= shift[1];
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  bit_cnt <= bit_cnt + CW'(1);
               end
            end
            STOP: begin
               if (bit_end) begin
                  bit_cnt <= '0;
                  if (do_pop) begin
                     shift  <= head;
                     tx_pin <= 1'b0;
                     state  <= START;
                  end else begin
                     state  <= IDLE;
                  end
               end else begin
                  bit_cnt <= bit_cnt + CW'(1);
               end
            end
            default: begin
               tx_pin <= 1'b1;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo.
// Instance a runs at the default 434 cycles/bit, instance b at 16 cycles/bit
// for the FIFO-full scenarios, instance c at 9600 baud (5208 cycles/bit).
module tb_uart_tx_fifo;

   logic clk;
   logic rst;
   int   cyc;
   int   n_checks;
   int   n_errors;

   logic [7:0] a_data, b_data, c_data;
   logic       a_valid, b_valid, c_valid;
   logic       a_ready, b_ready, c_ready;
   logic [4:0] a_count, b_count, c_count;
   logic       a_busy, b_busy, c_busy;
   logic       a_pin, b_pin, c_pin;

   logic [1:0] sel;
   logic       mon_pin;
   logic       mon_busy;

   uart_tx_fifo u_a (
      .clk(clk), .rst(rst), .tx_data(a_data), .tx_data_valid(a_valid),
      .tx_data_ready(a_ready), .fifo_count(a_count), .tx_busy(a_busy), .tx_pin(a_pin)
   );

   uart_tx_fifo #(.CLK_FRE(50), .BAUD_RATE(3_125_000), .FIFO_DEPTH(16)) u_b (
      .clk(clk), .rst(rst), .tx_data(b_data), .tx_data_valid(b_valid),
      .tx_data_ready(b_ready), .fifo_count(b_count), .tx_busy(b_busy), .tx_pin(b_pin)
   );

   uart_tx_fifo #(.CLK_FRE(50), .BAUD_RATE(9600), .FIFO_DEPTH(16)) u_c (
      .clk(clk), .rst(rst), .tx_data(c_data), .tx_data_valid(c_valid),
      .tx_data_ready(c_ready), .fifo_count(c_count), .tx_busy(c_busy), .tx_pin(c_pin)
   );

   assign mon_pin  = (sel == 2'd0) ? a_pin  : (sel == 2'd1) ? b_pin  : c_pin;
   assign mon_busy = (sel == 2'd0) ? a_busy : (sel == 2'd1) ? b_busy : c_busy;

   // 100 MHz bench clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Free-running cycle counter for measuring frame spacing.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Wait (bounded) for the monitored line to go low; ok reports success.
   task automatic wait_start(input int max_cycles, output logic ok);
      int k;
      k = 0;
      while (mon_pin !== 1'b0 && k < max_cycles) begin
         @(negedge clk);
         k++;
      end
      ok = (mon_pin === 1'b0);
   endtask

   // Receive one frame starting at the first sample of its start bit.
   // Every bit period must be constant; data is taken mid-bit.
   task automatic rx_frame(input int cpb, output logic [7:0] d, output logic shape_ok,
                           output int busy_hi);
      logic [9:0] bits;
      logic       first;
      int         bad;
      bad     = 0;
      busy_hi = 0;
      bits    = '0;
      for (int b = 0; b < 10; b++) begin
         first = mon_pin;
         for (int s = 0; s < cpb; s++) begin
            if (mon_pin !== first) bad++;
            if (s == cpb / 2) bits[b] = mon_pin;
            if (mon_busy === 1'b1) busy_hi++;
            @(negedge clk);
         end
      end
      d        = bits[8:1];
      shape_ok = (bad == 0) && (bits[0] == 1'b0) && (bits[9] == 1'b1);
   endtask

   // Length (bounded) of the current run of constant line level.
   task automatic run_len(input int max_cycles, output int n);
      logic v;
      v = mon_pin;
      n = 0;
      while (mon_pin === v && n < max_cycles) begin
         n++;
         @(negedge clk);
      end
   endtask

   initial begin
      logic [7:0] d;
      logic       ok;
      logic       shape;
      int         bh;
      int         busy_tot;
      int         t [3];
      int         n;

      n_checks = 0;
      n_errors = 0;
      cyc      = 0;
      sel      = 2'd0;
      rst      = 1'b1;
      a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
      a_data  = '0;   b_data  = '0;   c_data  = '0;

      // ---------------- reset state ----------------
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_pin",   a_pin,   1'b1);
      check("rst_count", a_count, 5'd0);
      check("rst_busy",  a_busy,  1'b0);
      check("rst_ready", a_ready, 1'b1);
      check("rst_b_c",   {b_pin, b_busy, b_ready, c_pin, c_busy, c_ready}, 6'b101101);

      // ---------------- single byte 0xA3 ----------------
      a_valid = 1'b1;
      a_data  = 8'hA3;
      @(negedge clk);
      a_valid = 1'b0;
      check("t1_count_after_write", a_count, 5'd1);
      check("t1_pin_after_write",   a_pin,   1'b1);
      busy_tot = (a_busy === 1'b1) ? 1 : 0;
      @(negedge clk);
      check("t1_count_after_pop", a_count, 5'd0);
      check("t1_pin_low",         a_pin,   1'b0);
      rx_frame(434, d, shape, bh);
      check("t1_data",       d,             8'hA3);
      check("t1_shape",      shape,         1'b1);
      check("t1_busy_len",   busy_tot + bh, 4341);
      check("t1_idle_after", {a_busy, a_pin}, 2'b01);

      // ---------------- three bytes back to back ----------------
      fork
         begin
            a_valid = 1'b1;
            a_data  = 8'h55;
            @(negedge clk);
            a_data  = 8'h00;
            @(negedge clk);
            a_data  = 8'hFF;
            @(negedge clk);
            a_valid = 1'b0;
         end
         begin
            wait_start(50, ok);
            check("t2_start_seen", ok, 1'b1);
            for (int i = 0; i < 3; i++) begin
               t[i] = cyc;
               rx_frame(434, d, shape, bh);
               check("t2_shape", shape, 1'b1);
               check("t2_data", d, (i == 0) ? 8'h55 : (i == 1) ? 8'h00 : 8'hFF);
            end
         end
      join
      check("t2_gap01",  t[1] - t[0], 4340);
      check("t2_gap12",  t[2] - t[1], 4340);
      check("t2_idle",   {a_busy, a_pin, a_count}, {2'b01, 5'd0});

      // ---------------- FIFO full, pop/write collisions (instance b) ----------------
      sel = 2'd1;
      fork
         begin
            int  nv;
            int  k;
            logic acc;
            nv      = 0;
            b_data  = 8'h00;
            b_valid = 1'b1;
            for (int i = 0; i < 30; i++) begin
               acc = b_ready;
               @(negedge clk);
               if (acc) begin
                  nv++;
                  b_data = 8'(nv);
               end
            end
            check("t3_accepted", nv,      17);
            check("t3_ready",    b_ready, 1'b0);
            check("t3_count",    b_count, 5'd16);
            check("t3_pending",  b_data,  8'h11);
            // Hold 0x11 valid across the pop edge; it must not be stored there.
            k = 0;
            while (b_count == 5'd16 && k < 400) begin
               @(negedge clk);
               k++;
            end
            check("t4_count_after_pop", b_count, 5'd15);
            check("t4_ready_after_pop", b_ready, 1'b1);
            @(negedge clk);
            b_valid = 1'b0;
            check("t4_count_refill", b_count, 5'd16);
            check("t4_ready_refill", b_ready, 1'b0);
            // Next pop drops to 15; the one after that coincides with a write.
            k = 0;
            while (b_count == 5'd16 && k < 400) begin
               @(negedge clk);
               k++;
            end
            check("t4_count_pop2", b_count, 5'd15);
            repeat (159) @(negedge clk);
            b_valid = 1'b1;
            b_data  = 8'h12;
            @(negedge clk);
            b_valid = 1'b0;
            check("t4_write_pop_same_edge", b_count, 5'd15);
         end
         begin
            int nbad;
            nbad = 0;
            wait_start(50, ok);
            check("t3_start_seen", ok, 1'b1);
            for (int i = 0; i < 19; i++) begin
               rx_frame(16, d, shape, bh);
               if (!shape) nbad++;
               check("t3_line_byte", d, 8'(i));
            end
            check("t3_shape_errors", nbad, 0);
         end
      join
      check("t3_idle", {b_busy, b_pin, b_count}, {2'b01, 5'd0});

      // ---------------- reset mid-frame ----------------
      sel     = 2'd0;
      a_valid = 1'b1;
      a_data  = 8'hA3;
      @(negedge clk);
      a_data  = 8'h11;
      @(negedge clk);
      a_data  = 8'h22;
      @(negedge clk);
      a_data  = 8'h33;
      @(negedge clk);
      a_data  = 8'h44;
      @(negedge clk);
      a_valid = 1'b0;
      check("t5_queued", a_count, 5'd4);
      // Middle of data bit 3 (value 0) of 0xA3.
      repeat (1946) @(negedge clk);
      check("t5_pin_bit3", a_pin, 1'b0);
      rst = 1'b1;
      #1;
      check("t5_rst_pin",   a_pin,   1'b1);
      check("t5_rst_count", a_count, 5'd0);
      check("t5_rst_busy",  a_busy,  1'b0);
      check("t5_rst_ready", a_ready, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("t5_idle_after_rst", {a_busy, a_pin}, 2'b01);
      a_valid = 1'b1;
      a_data  = 8'h3C;
      @(negedge clk);
      a_valid = 1'b0;
      wait_start(10, ok);
      check("t5_start_seen", ok, 1'b1);
      rx_frame(434, d, shape, bh);
      check("t5_data",  d,     8'h3C);
      check("t5_shape", shape, 1'b1);
      n = 0;
      for (int i = 0; i < 868; i++) begin
         if (a_pin !== 1'b1 || a_busy !== 1'b0) n++;
         @(negedge clk);
      end
      check("t5_no_leftover", n, 0);
      check("t5_count_end", a_count, 5'd0);

      // ---------------- 9600 baud bit period ----------------
      sel     = 2'd2;
      c_valid = 1'b1;
      c_data  = 8'h81;
      @(negedge clk);
      c_valid = 1'b0;
      wait_start(10, ok);
      check("t6_start_seen", ok, 1'b1);
      run_len(6000, n);
      check("t6_start_len", n, 5208);
      run_len(6000, n);
      check("t6_d0_len", n, 5208);
      check("t6_d1_low", c_pin, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte-oriented UART transmitter with an internal transmit FIFO: the inverse of the receive path exercised by the UART loopback demo. A producer pushes bytes over a valid/ready handshake; the block serialises them as 8N1 frames on `tx_pin`, LSB first, with no idle gap between queued bytes. It sits between a user data source (echo logic, message ROM) and the board's UART TX pin.

## Interface
- `CLK_FRE`, 50, system clock frequency in MHz.
- `BAUD_RATE`, 115200, line rate in bit/s.
- `FIFO_DEPTH`, 16, FIFO entries; power of two, ≥ 2.
- `clk` input 1: system clock. One clock domain.
- `rst` input 1: reset, asynchronous, active-high.
- `tx_data` input 8: byte to send.
- `tx_data_valid` input 1: producer has a byte on `tx_data`.
- `tx_data_ready` output 1: FIFO can accept a byte (= not full).
- `fifo_count` output $clog2(FIFO_DEPTH)+1: bytes waiting in FIFO, excluding the byte being shifted.
- `tx_busy` output 1: high while a frame is on the line or the FIFO is non-empty.
- `tx_pin` output 1: serial line, idle high, registered.

## Operation
- Bit period `CYCLES_PER_BIT = CLK_FRE*1_000_000 / BAUD_RATE`, integer truncation (434 at defaults, 8680 ns). Bit counter counts 0..CYCLES_PER_BIT-1.
- Frame: start bit 0, data bits d0..d7 in that order, one stop bit 1. 10 bit periods = 4340 cycles at defaults.
- Write: byte accepted on an edge where `tx_data_valid && tx_data_ready`. When full, `tx_data_ready` = 0 and `tx_data_valid` is ignored (byte not stored, no error).
- FIFO: circular buffer, read/write pointers one bit wider than the address and wrapping naturally. Write and pop on the same edge leave `fifo_count` unchanged. When full, only a pop can occur.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: `tx_pin` = 1. If FIFO non-empty: pop head into shift register, clear bit counter, → START.
  - START: `tx_pin` = 0 for one bit period → DATA with bit index 0.
  - DATA: `tx_pin` = shift[0]; at the end of each period shift right and increment index; after index 7 → STOP.
  - STOP: `tx_pin` = 1 for one bit period. At its end, if FIFO non-empty, pop and → START on the same edge (back-to-back, no idle gap); else → IDLE.
- `tx_busy` = (state ≠ IDLE) || (`fifo_count` ≠ 0).

## Timing
- Reset (asynchronous, any time including mid-frame): `tx_pin` = 1, state IDLE, FIFO emptied, pointers 0, `fifo_count` = 0, `tx_busy` = 0, `tx_data_ready` = 1. A partially sent frame is abandoned; no stop bit is completed.
- Latency: with the block idle and the FIFO empty, a byte accepted at edge N drives `tx_pin` low after edge N+1. `fifo_count` reads 1 after edge N and 0 after edge N+1.
- Each bit lasts exactly CYCLES_PER_BIT cycles. Back-to-back frames are exactly 10·CYCLES_PER_BIT cycles apart.
- `tx_data_ready` deasserts the cycle after the write that fills the FIFO. It reasserts the cycle after the next pop.
- `tx_busy` falls on the edge that ends the last stop bit when the FIFO is empty.
- Total storage is FIFO_DEPTH + 1 bytes: the FIFO plus the shift register.

## Test plan
- Single byte 0xA3 after reset. Expect `tx_pin`: 0 for 434 cycles, then 1,1,0,0,0,1,0,1 for 434 cycles each, then 1. `tx_busy` is high for 4341 cycles total.
- Three bytes 0x55, 0x00, 0xFF written on consecutive cycles. Expect three contiguous frames with no idle between stop and next start, each start edge 4340 cycles apart, decoded by a bench receiver as 0x55, 0x00, 0xFF.
- Hold `tx_data_valid` high with incrementing bytes 0x00 upward. Expect 17 accepted (1 shifting + 16 queued), `tx_data_ready` = 0 and `fifo_count` = 16. Byte 0x11 is not stored; it is accepted only after the next pop. Line output is 0x00..0x10 in order.
- Full FIFO with a write attempted on the exact edge of a pop. Expect no write while ready = 0. Ready rises after the pop and the next write succeeds with `fifo_count` returning to 16. Also cover a write coinciding with a pop when not full: count unchanged.
- Assert `rst` during DATA bit 3 of 0xA3 with 4 bytes queued. Expect `tx_pin` = 1 immediately, `fifo_count` = 0, `tx_busy` = 0. After release, a new 0x3C is sent intact with no leftover bytes.
- Parameter check: CLK_FRE = 50, BAUD_RATE = 9600. Expect a bit period of 5208 cycles, verified on byte 0x81.
